// File: rtl/ysyx_23060201_dmem_wr_resp_if.sv
// Store-request / write-response bundle between the execute stage and the data-memory responder.
// Also carries the busy flag and the combinational debug read port.
interface ysyx_23060201_dmem_wr_resp_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_data;
    logic [7:0]            req_mask;
    logic                  resp_valid;
    logic                  resp_ready;
    logic                  resp_err;
    logic                  busy;
    logic [ADDR_WIDTH-1:0] dbg_addr;
    logic [DATA_WIDTH-1:0] dbg_data;

    modport master (
        output req_valid, req_addr, req_data, req_mask, resp_ready, dbg_addr,
        input  req_ready, resp_valid, resp_err, busy, dbg_data
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_mask, resp_ready, dbg_addr,
        output req_ready, resp_valid, resp_err, busy, dbg_data
    );
endinterface

// File: rtl/ysyx_23060201_dmem_wr_resp.sv
// Data-memory store responder: 2-entry request FIFO, programmable commit latency,
// byte-lane writes into a word memory, done/error response and a debug read port.
module ysyx_23060201_dmem_wr_resp #(
    parameter int unsigned          ADDR_WIDTH = 32,
    parameter int unsigned          DATA_WIDTH = 32,
    parameter int unsigned          DEPTH      = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE      = 32'h8000_0000,
    parameter int unsigned          LAT        = 2
) (
    input logic                          clk,
    input logic                          rst_n,
    ysyx_23060201_dmem_wr_resp_if.slave  bus
);
    localparam int unsigned           IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-3:0] DEPTH_W = (ADDR_WIDTH-2)'(DEPTH);
    localparam logic [3:0]            LAT_CNT = 4'(LAT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic [7:0] lane_enable(input logic [3:0] mask, input logic [1:0] ofs);
        return {4'b0000, mask} << ofs;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] lane_data(input logic [DATA_WIDTH-1:0] data,
                                                        input logic [1:0] ofs);
        return data << {ofs, 3'b000};
    endfunction

    logic [ADDR_WIDTH-1:0] fifo_addr_r [2];
    logic [DATA_WIDTH-1:0] fifo_data_r [2];
    logic [3:0]            fifo_mask_r [2];
    logic                  wr_ptr_r;
    logic                  rd_ptr_r;
    logic [1:0]            count_r;
    logic [1:0]            count_nxt_s;
    logic                  req_ready_r;
    logic                  push_s;
    logic                  pop_s;

    state_t                state_r;
    logic [3:0]            cnt_r;
    logic                  resp_valid_r;
    logic                  resp_err_r;
    logic                  busy_r;
    logic [ADDR_WIDTH-1:0] w_addr_r;
    logic [DATA_WIDTH-1:0] w_data_r;
    logic [3:0]            w_mask_r;

    logic [ADDR_WIDTH-1:0] offset_s;
    logic [ADDR_WIDTH-3:0] idx_s;
    logic [7:0]            be_s;
    logic [DATA_WIDTH-1:0] wdata_s;
    logic                  err_s;
    logic                  commit_s;

    logic [ADDR_WIDTH-1:0] dbg_off_s;
    logic [ADDR_WIDTH-3:0] dbg_idx_s;
    logic                  unused_s;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    assign push_s = bus.req_valid & req_ready_r;
    assign pop_s  = (state_r == ST_IDLE) & (count_r != 2'd0);

    // FIFO occupancy after this edge; ready is derived from it, never from the pop
    always_comb begin
        count_nxt_s = count_r;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + 2'd1;
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_r - 2'd1;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Request FIFO storage, pointers and registered ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r    <= 1'b0;
            rd_ptr_r    <= 1'b0;
            count_r     <= 2'd0;
            req_ready_r <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                fifo_addr_r[i] <= '0;
                fifo_data_r[i] <= '0;
                fifo_mask_r[i] <= 4'h0;
            end
        end else begin
            if (push_s) begin
                fifo_addr_r[wr_ptr_r] <= bus.req_addr;
                fifo_data_r[wr_ptr_r] <= bus.req_data;
                fifo_mask_r[wr_ptr_r] <= bus.req_mask[3:0];
                wr_ptr_r              <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r     <= count_nxt_s;
            req_ready_r <= (count_nxt_s < 2'd2);
        end
    end

    // Address decode of the working request; addresses below BASE wrap to a huge index
    assign offset_s = w_addr_r - BASE;
    assign idx_s    = offset_s[ADDR_WIDTH-1:2];
    assign be_s     = lane_enable(w_mask_r, w_addr_r[1:0]);
    assign wdata_s  = lane_data(w_data_r, w_addr_r[1:0]);
    assign err_s    = (be_s[7:4] != 4'h0) | (idx_s >= DEPTH_W);
    assign commit_s = (state_r == ST_WAIT) & (cnt_r == 4'd0) & ~err_s;

    // Transaction FSM with registered response and busy outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 4'd0;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            busy_r       <= 1'b0;
            w_addr_r     <= '0;
            w_data_r     <= '0;
            w_mask_r     <= 4'h0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        w_addr_r <= fifo_addr_r[rd_ptr_r];
                        w_data_r <= fifo_data_r[rd_ptr_r];
                        w_mask_r <= fifo_mask_r[rd_ptr_r];
                        cnt_r    <= LAT_CNT;
                        state_r  <= ST_WAIT;
                        busy_r   <= 1'b1;
                    end else begin
                        busy_r   <= (count_nxt_s != 2'd0);
                    end
                end
                ST_WAIT: begin
                    busy_r <= 1'b1;
                    if (cnt_r == 4'd0) begin
                        resp_err_r   <= err_s;
                        resp_valid_r <= 1'b1;
                        state_r      <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_r <= 1'b0;
                        resp_err_r   <= 1'b0;
                        state_r      <= ST_IDLE;
                        busy_r       <= (count_nxt_s != 2'd0);
                    end else begin
                        busy_r <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    resp_valid_r <= 1'b0;
                    resp_err_r   <= 1'b0;
                    busy_r       <= (count_nxt_s != 2'd0);
                end
            endcase
        end
    end

    // Byte-lane commit; the array keeps its contents across reset
    always_ff @(posedge clk) begin
        if (commit_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_r[idx_s[IDX_W-1:0]][8*i +: 8] <= wdata_s[8*i +: 8];
                end
            end
        end
    end

    assign dbg_off_s = bus.dbg_addr - BASE;
    assign dbg_idx_s = dbg_off_s[ADDR_WIDTH-1:2];

    // Debug read: word lookup, zero outside the mapped window
    always_comb begin
        bus.dbg_data = '0;
        if (dbg_idx_s < DEPTH_W) begin
            bus.dbg_data = mem_r[dbg_idx_s[IDX_W-1:0]];
        end else begin
            bus.dbg_data = '0;
        end
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_err   = resp_err_r;
    assign bus.busy       = busy_r;

    assign unused_s = ^{offset_s[1:0], dbg_off_s[1:0], bus.req_mask[7:4]};
endmodule

// File: tb/tb_ysyx_23060201_dmem_wr_resp.sv
// Bench for the store responder: vector table with an error scoreboard, plus
// back-pressure, LAT=0 and reset-mid-transaction sequences.
module tb_ysyx_23060201_dmem_wr_resp;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    ysyx_23060201_dmem_wr_resp_if b0 ();
    ysyx_23060201_dmem_wr_resp_if b1 ();

    ysyx_23060201_dmem_wr_resp #(.LAT(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
    ysyx_23060201_dmem_wr_resp #(.LAT(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [7:0]  mask;
        logic        err;
        logic [31:0] chk_addr;
        logic [31:0] chk_word;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    task automatic send0(input logic [31:0] a, input logic [31:0] d, input logic [7:0] m,
                         input logic e);
        int n;
        n = 0;
        b0.req_valid = 1'b1;
        b0.req_addr  = a;
        b0.req_data  = d;
        b0.req_mask  = m;
        while (b0.req_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            timeout_fail("send_accept");
        end else begin
            @(posedge clk); #1;
            exp_q.push_back(e);
        end
        b0.req_valid = 1'b0;
    endtask

    task automatic recv0(input string name, output int lat);
        int   n;
        logic e;
        n = 0;
        b0.resp_ready = 1'b1;
        while (b0.resp_valid !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        lat = n;
        if (n >= 100) begin
            timeout_fail({name, "_resp"});
        end else begin
            if (exp_q.size() == 0) begin
                timeout_fail({name, "_unexpected"});
            end else begin
                e = exp_q.pop_front();
                check(name, {31'd0, b0.resp_err}, {31'd0, e});
            end
            @(posedge clk); #1;
        end
        b0.resp_ready = 1'b0;
    endtask

    task automatic store1(input logic [31:0] a, input logic [31:0] d, input logic [7:0] m,
                          output int lat, output logic err);
        int n;
        n = 0;
        b1.req_valid = 1'b1;
        b1.req_addr  = a;
        b1.req_data  = d;
        b1.req_mask  = m;
        @(posedge clk); #1;
        b1.req_valid = 1'b0;
        while (b1.resp_valid !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        lat = n;
        err = b1.resp_err;
        b1.resp_ready = 1'b1;
        @(posedge clk); #1;
        b1.resp_ready = 1'b0;
    endtask

    initial begin
        int   lat;
        logic err;

        vecs[0]  = '{32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 1'b0, 32'h8000_0010, 32'hDEAD_BEEF};
        vecs[1]  = '{32'h8000_0020, 32'h1122_3344, 8'h0F, 1'b0, 32'h8000_0020, 32'h1122_3344};
        vecs[2]  = '{32'h8000_0021, 32'h0000_00AB, 8'h01, 1'b0, 32'h8000_0020, 32'h1122_AB44};
        vecs[3]  = '{32'h8000_0022, 32'h0000_CDEF, 8'h03, 1'b0, 32'h8000_0020, 32'hCDEF_AB44};
        vecs[4]  = '{32'h8000_0000, 32'h0102_0304, 8'h0F, 1'b0, 32'h8000_0000, 32'h0102_0304};
        vecs[5]  = '{32'h8000_0003, 32'h0000_FFFF, 8'h03, 1'b1, 32'h8000_0000, 32'h0102_0304};
        vecs[6]  = '{32'h8000_0400, 32'h5555_5555, 8'h0F, 1'b1, 32'h8000_0000, 32'h0102_0304};
        vecs[7]  = '{32'h8000_03FC, 32'hA5A5_A5A5, 8'h0F, 1'b0, 32'h8000_03FC, 32'hA5A5_A5A5};
        vecs[8]  = '{32'h7FFF_FFFC, 32'h5A5A_5A5A, 8'h0F, 1'b1, 32'h8000_03FC, 32'hA5A5_A5A5};
        vecs[9]  = '{32'h8000_0010, 32'hFFFF_FFFF, 8'h00, 1'b0, 32'h8000_0010, 32'hDEAD_BEEF};
        vecs[10] = '{32'h8000_0013, 32'h0000_0077, 8'h01, 1'b0, 32'h8000_0010, 32'h77AD_BEEF};
        vecs[11] = '{32'h8000_0020, 32'h0000_0099, 8'hF1, 1'b0, 32'h8000_0020, 32'hCDEF_AB99};
        vecs[12] = '{32'h8000_0001, 32'h0000_CCBB, 8'h03, 1'b0, 32'h8000_0000, 32'h01CC_BB04};
        vecs[13] = '{32'h8000_0040, 32'hCAFE_F00D, 8'h0F, 1'b0, 32'h8000_0040, 32'hCAFE_F00D};

        b0.req_valid = 1'b0; b0.req_addr = 32'h0; b0.req_data = 32'h0; b0.req_mask = 8'h0;
        b0.resp_ready = 1'b0; b0.dbg_addr = 32'h8000_0000;
        b1.req_valid = 1'b0; b1.req_addr = 32'h0; b1.req_data = 32'h0; b1.req_mask = 8'h0;
        b1.resp_ready = 1'b0; b1.dbg_addr = 32'h8000_0000;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_req_ready", {31'd0, b0.req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, b0.resp_valid}, 32'd0);
        check("rst_resp_err", {31'd0, b0.resp_err}, 32'd0);
        check("rst_busy", {31'd0, b0.busy}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) begin
            send0(vecs[i].addr, vecs[i].data, vecs[i].mask, vecs[i].err);
            recv0($sformatf("vec%0d_err", i), lat);
            if (i == 0) check("lat2_latency", 32'(lat), 32'd4);
            b0.dbg_addr = vecs[i].chk_addr;
            #1;
            check($sformatf("vec%0d_word", i), b0.dbg_data, vecs[i].chk_word);
        end
        b0.dbg_addr = 32'h8000_0400;
        #1;
        check("dbg_out_of_range", b0.dbg_data, 32'h0);

        // Back-pressure: three stores queue up while the response is held
        send0(32'h8000_0050, 32'h0000_0001, 8'h0F, 1'b0);
        send0(32'h8000_0051, 32'h0000_0002, 8'h0F, 1'b1);
        send0(32'h8000_0050, 32'h0000_0003, 8'h0F, 1'b0);
        check("bp_full_ready", {31'd0, b0.req_ready}, 32'd0);
        check("bp_busy", {31'd0, b0.busy}, 32'd1);
        repeat (6) begin @(posedge clk); #1; end
        check("bp_hold_valid", {31'd0, b0.resp_valid}, 32'd1);
        check("bp_hold_ready", {31'd0, b0.req_ready}, 32'd0);
        b0.dbg_addr = 32'h8000_0050;
        recv0("bp1_err", lat);
        check("bp1_word", b0.dbg_data, 32'h0000_0001);
        recv0("bp2_err", lat);
        recv0("bp3_err", lat);
        check("bp3_word", b0.dbg_data, 32'h0000_0003);

        // LAT=0 instance: latency and zero-mask store
        store1(32'h8000_0010, 32'h1234_5678, 8'h0F, lat, err);
        check("lat0_latency", 32'(lat), 32'd2);
        check("lat0_err", {31'd0, err}, 32'd0);
        b1.dbg_addr = 32'h8000_0010;
        #1;
        check("lat0_word", b1.dbg_data, 32'h1234_5678);
        store1(32'h8000_0010, 32'hFFFF_FFFF, 8'h00, lat, err);
        check("lat0_zero_mask_err", {31'd0, err}, 32'd0);
        check("lat0_zero_mask_word", b1.dbg_data, 32'h1234_5678);

        // Reset while the store to 0x8000_0040 sits in WAIT
        send0(32'h8000_0040, 32'h0BAD_BEEF, 8'h0F, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("wait_busy", {31'd0, b0.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("mid_rst_req_ready", {31'd0, b0.req_ready}, 32'd1);
        check("mid_rst_resp_valid", {31'd0, b0.resp_valid}, 32'd0);
        check("mid_rst_resp_err", {31'd0, b0.resp_err}, 32'd0);
        check("mid_rst_busy", {31'd0, b0.busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (8) begin @(posedge clk); #1; end
        check("post_rst_no_resp", {31'd0, b0.resp_valid}, 32'd0);
        b0.dbg_addr = 32'h8000_0040;
        #1;
        check("post_rst_word_kept", b0.dbg_data, 32'hCAFE_F00D);
        send0(32'h8000_0040, 32'h600D_F00D, 8'h0F, 1'b0);
        recv0("post_rst_err", lat);
        check("post_rst_latency", 32'(lat), 32'd4);
        check("post_rst_word", b0.dbg_data, 32'h600D_F00D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ysyx_23060201_dmem_wr_resp.md
Name: ysyx_23060201_dmem_wr_resp

Overview:
- Store-side responder for the core's data-memory write interface: accepts byte-masked store requests (address, data, mask) through a valid/ready handshake.
- Buffers requests in a 2-entry FIFO, models a programmable write latency, commits byte lanes into an internal word-organised memory, and returns a done/error response.
- Sits between the execute stage's store outputs and the simulated data memory.
- A combinational debug read port exposes memory contents to the bench.

Parameters:
- ADDR_WIDTH, 32, request address width.
- DATA_WIDTH, 32, data width; fixed at 32, lanes are bytes.
- DEPTH, 256, number of 32-bit memory words.
- BASE, 32'h8000_0000, byte address of word 0.
- LAT, 2, extra wait cycles before commit (0..15).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  store request valid.
- req_ready  out  1  request slot available.
- req_addr  in  32  store byte address.
- req_data  in  32  store data, byte 0 in bits [7:0].
- req_mask  in  8  byte mask; bits [3:0] used, bits [7:4] ignored.
- resp_valid  out  1  write response valid.
- resp_ready  in  1  response accepted.
- resp_err  out  1  1 = request rejected (misaligned or out of range), 0 = ok.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- dbg_addr  in  32  debug byte address (word-aligned use).
- dbg_data  out  32  memory word at dbg_addr; 0 if out of range.

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous, active-low (rst_n), on clk rising edge.
- Reset values: req_ready=1, resp_valid=0, resp_err=0, busy=0, FIFO count=0, FSM=IDLE, latency counter=0. Memory array is not reset; contents are retained across rst_n.
- Request handshake:
  - A request is accepted on a rising edge with req_valid && req_ready, and is pushed into the FIFO.
  - req_ready = (count < 2), derived from count only. When full, ready stays low even if a pop happens in the same cycle.
  - Push and pop in the same cycle leave count unchanged. The FIFO preserves order.
- FSM states IDLE, WAIT, RESP:
  - IDLE: if the FIFO is non-empty, pop the head into the working registers, load cnt=LAT, and go to WAIT.
  - WAIT: if cnt==0, commit, register resp_err, and go to RESP; otherwise cnt--.
  - RESP: resp_valid=1, and resp_err is held stable. On resp_valid && resp_ready, go to IDLE. There is no pop in the same edge.
- Latency: request accepted at edge A into an empty, idle block → pop at A+1 → commit at A+2+LAT → resp_valid high in the cycle after edge A+2+LAT.
- Lane and address rules:
  - offset = addr - BASE (32-bit unsigned); word index = offset[31:2].
  - Byte enable be = {4'b0, mask[3:0]} << addr[1:0] (8 bits).
  - Misaligned: be[7:4] != 0 → resp_err=1, memory untouched.
  - Out of range: word index >= DEPTH, including addr < BASE via wrap → resp_err=1, memory untouched.
  - Otherwise, each be[i] for i in 0..3 writes mem[index][8i+7:8i] = data byte rotated by addr[1:0] (data << 8*addr[1:0]). Unselected bytes are unchanged.
  - mask[3:0]==0: no write, resp_err=0.
- Error priority: misaligned is checked before range; both give the same resp_err=1.
- Debug port: dbg_data is combinational, reflects a commit on the cycle after the commit edge, and uses dbg_addr[1:0] ignored.
- Reset mid-operation: FIFO entries and any in-flight WAIT/RESP transaction are dropped with no commit and no response. Memory keeps prior commits.
- Back-pressure: resp_ready low holds RESP indefinitely. The FIFO continues accepting until full.

Test Plan:
- Word store, LAT=2: addr=0x8000_0010, data=0xDEADBEEF, mask=0x0F → resp_valid with resp_err=0 visible after edge A+4; dbg_addr=0x8000_0010 reads 0xDEADBEEF.
- Byte/half stores: prefill word 0x8000_0020 = 0x11223344.
  - Store addr=0x8000_0021, data=0x000000AB, mask=0x01 → word=0x1122AB44.
  - Then addr=0x8000_0022, data=0x0000CDEF, mask=0x03 → word=0xCDEFAB44.
- Misaligned and out-of-range:
  - addr=0x8000_0003, mask=0x03 → resp_err=1, word unchanged.
  - addr=0x8000_0400 (DEPTH=256) → resp_err=1.
  - addr=0x7FFF_FFFC → resp_err=1.
- FIFO full and back-pressure: hold resp_ready=0 and issue 3 back-to-back requests.
  - req_ready goes low once 2 are queued behind the active one.
  - Release resp_ready → three responses in order; the final memory reflects the last store.
- Zero mask and LAT=0 build: mask=0x00 → resp_err=0, memory unchanged. With LAT=0, resp_valid is visible after edge A+2.
- Reset mid-WAIT: assert rst_n=0 while the FSM is in WAIT for addr 0x8000_0040.
  - Outputs return to reset values immediately (asynchronously), and no response is produced.
  - Word 0x8000_0040 is unchanged; a subsequent store after reset works normally.
